vjtag_scan_sequencer: RTL

- Synthesizable master that sequences a JTAG TAP (virtual JTAG hub/TAP pair, or any IEEE 1149.1 TAP) from a host-side command/response interface.
- Generates jtag_tck/jtag_tms/jtag_tdi for TAP reset, IR scans, DR scans and idle clocking, and returns the captured jtag_tdo bits.
- Sits between an AFU/CSR-side requester and the TAP, replacing canned stimulus with run-time scans.

---
 rtl/vjtag_scan_sequencer.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/vjtag_scan_sequencer.sv
// rtl/vjtag_scan_sequencer.sv - JTAG TAP scan sequencer driven by a command/response interface
module vjtag_scan_sequencer #(
    parameter int MAX_LEN  = 32,
    parameter int LEN_W    = 6,
    parameter int TCK_HALF = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               jtag_tck,
    output logic               jtag_tms,
    output logic               jtag_tdi,
    input  logic               jtag_tdo
);

    localparam int CNT_W = $clog2(2 * TCK_HALF);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CNT_W-1:0] RISE_AT   = CNT_W'(TCK_HALF - 1);
    localparam logic [CNT_W-1:0] FALL_AT   = CNT_W'(2 * TCK_HALF - 1);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    localparam logic [1:0] OP_DR   = 2'b00;
    localparam logic [1:0] OP_IR   = 2'b01;
    localparam logic [1:0] OP_RST  = 2'b10;
    localparam logic [1:0] OP_IDLE = 2'b11;

    typedef enum logic [2:0] {TLR_SEQ, IDLE, PRE, SHIFT, POST, RSP} state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   step_q, step_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tck_q, tck_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic [1:0]         op_q, op_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [MAX_LEN-1:0] data_q, data_d;
    logic [MAX_LEN-1:0] rsp_q, rsp_d;

    logic               active;
    logic               rise;
    logic               fall;
    logic               accept;
    logic [LEN_W-1:0]   len_eff;
    logic [LEN_W-1:0]   seg_len;
    logic               seg_last;
    logic               pos_tms;
    logic               pos_tdi;

    assign active = (state_q == TLR_SEQ) || (state_q == PRE) ||
                    (state_q == SHIFT)   || (state_q == POST);
    assign rise   = active && (cnt_q == RISE_AT);
    assign fall   = active && (cnt_q == FALL_AT);
    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        len_eff = cmd_len;
        if (cmd_len == '0) begin
            len_eff = LEN_W'(1);
        end else if (cmd_len > MAX_LEN_L) begin
            len_eff = MAX_LEN_L;
        end
    end

    // Number of TCKs spent in the current segment
    always_comb begin
        seg_len = LEN_W'(1);
        case (state_q)
            TLR_SEQ: seg_len = LEN_W'(6);
            PRE: begin
                case (op_q)
                    OP_DR:   seg_len = LEN_W'(3);
                    OP_IR:   seg_len = LEN_W'(4);
                    OP_RST:  seg_len = LEN_W'(6);
                    default: seg_len = len_q;
                endcase
            end
            SHIFT:   seg_len = len_q;
            POST:    seg_len = LEN_W'(2);
            default: seg_len = LEN_W'(1);
        endcase
    end

    assign seg_last = (step_q == (seg_len - LEN_W'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TLR_SEQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = PRE;
                    step_d  = '0;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                if (fall) begin
                    if (seg_last) begin
                        step_d = '0;
                        case (state_q)
                            TLR_SEQ: state_d = IDLE;
                            PRE:     state_d = ((op_q == OP_DR) || (op_q == OP_IR)) ? SHIFT : RSP;
                            SHIFT:   state_d = POST;
                            POST:    state_d = RSP;
                            default: state_d = IDLE;
                        endcase
                    end else begin
                        step_d = step_q + LEN_W'(1);
                    end
                end
            end
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == IDLE);
        rsp_valid = (state_q == RSP);
        busy      = (state_q != IDLE) && (state_q != RSP);
        jtag_tck  = tck_q;
        jtag_tms  = tms_q;
        jtag_tdi  = tdi_q;
        rsp_data  = rsp_q;
    end

    assign op_d   = accept ? cmd_op   : op_q;
    assign len_d  = accept ? len_eff  : len_q;
    assign data_d = accept ? cmd_data : data_q;

    // TMS/TDI for the TCK about to start, looked up from the next position
    always_comb begin
        pos_tms = 1'b0;
        pos_tdi = 1'b0;
        case (state_d)
            TLR_SEQ: pos_tms = (step_d < LEN_W'(5));
            PRE: begin
                case (op_d)
                    OP_DR:   pos_tms = (step_d == '0);
                    OP_IR:   pos_tms = (step_d < LEN_W'(2));
                    OP_RST:  pos_tms = (step_d < LEN_W'(5));
                    default: pos_tms = 1'b0;
                endcase
            end
            SHIFT: begin
                pos_tms = (step_d == (len_d - LEN_W'(1)));
                pos_tdi = data_d[step_d[IDX_W-1:0]];
            end
            POST:    pos_tms = (step_d == '0);
            default: pos_tms = 1'b0;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        tck_d = tck_q;
        tms_d = tms_q;
        tdi_d = tdi_q;
        rsp_d = rsp_q;
        if (accept) begin
            cnt_d = '0;
            tck_d = 1'b0;
            tms_d = pos_tms;
            tdi_d = pos_tdi;
            rsp_d = '0;
        end else if (active) begin
            cnt_d = fall ? '0 : cnt_q + CNT_W'(1);
            if (rise) begin
                tck_d = 1'b1;
                if (state_q == SHIFT) begin
                    rsp_d[step_q[IDX_W-1:0]] = jtag_tdo;
                end
            end
            if (fall) begin
                tck_d = 1'b0;
                tms_d = pos_tms;
                tdi_d = pos_tdi;
            end
        end else if ((state_q == RSP) && rsp_ready) begin
            rsp_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q <= '0;
            cnt_q  <= '0;
            tck_q  <= 1'b0;
            tms_q  <= 1'b1;
            tdi_q  <= 1'b0;
            op_q   <= OP_DR;
            len_q  <= LEN_W'(1);
            data_q <= '0;
            rsp_q  <= '0;
        end else begin
            step_q <= step_d;
            cnt_q  <= cnt_d;
            tck_q  <= tck_d;
            tms_q  <= tms_d;
            tdi_q  <= tdi_d;
            op_q   <= op_d;
            len_q  <= len_d;
            data_q <= data_d;
            rsp_q  <= rsp_d;
        end
    end

endmodule
